// File: rtl/ex_issue_ctrl_pkg.sv
// Shared encodings for the ID/EX issue stage: ALU unit selects, issue FSM states
// and the default register-index width.
package ex_issue_ctrl_pkg;

  localparam int REG_AW = 5;

  typedef enum logic [2:0] {
    ALU_ADD    = 3'b000,
    ALU_SHIFT  = 3'b001,
    ALU_DIV    = 3'b010,
    ALU_MUL    = 3'b011,
    ALU_LOGIC  = 3'b100,
    ALU_CMP    = 3'b101,
    ALU_BRANCH = 3'b110,
    ALU_BUBBLE = 3'b111
  } ialu_ctrl_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_DIV_WAIT = 2'd2
  } issue_state_e;

endpackage

// File: rtl/ex_issue_ctrl_operand_fwd_mux.sv
// Per-source operand select: EX result, then WB data, then register-file value.
// x0 and immediates always take the register-file/immediate value.
module operand_fwd_mux #(
  parameter int XLEN   = 32,
  parameter int REG_AW = ex_issue_ctrl_pkg::REG_AW
) (
  input  logic [REG_AW-1:0] idx,
  input  logic              use_imm,
  input  logic [XLEN-1:0]   rf_val,
  input  logic [REG_AW-1:0] ex_rd_idx,
  input  logic [XLEN-1:0]   alu_result,
  input  logic              wb_valid,
  input  logic [REG_AW-1:0] wb_rd_idx,
  input  logic [XLEN-1:0]   wb_data,
  output logic [XLEN-1:0]   val
);

  // ex_rd_idx reads 0 on a bubble, so the x0 guard also covers an empty EX slot.
  always_comb begin
    val = rf_val;
    if (!use_imm && idx != '0) begin
      if (idx == ex_rd_idx)                  val = alu_result;
      else if (wb_valid && idx == wb_rd_idx) val = wb_data;
    end
  end

endmodule

// File: rtl/ex_issue_ctrl.sv
// ID/EX issue stage feeding the integer ALU; stalls while the divider runs.
// Define OPERAND_FWD_EN to build EX/WB operand forwarding.
module ex_issue_ctrl #(
  parameter int XLEN        = 32,
  parameter int REG_AW      = ex_issue_ctrl_pkg::REG_AW,
  parameter int DIV_MAX_CYC = 40
) (
  input  logic              CLK,
  input  logic              rst_n,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [XLEN-1:0]   id_rs1_val,
  input  logic [XLEN-1:0]   id_rs2_val,
  input  logic [REG_AW-1:0] id_rs1_idx,
  input  logic [REG_AW-1:0] id_rs2_idx,
  input  logic              id_use_imm,
  input  logic [REG_AW-1:0] id_rd_idx,
  input  logic [2:0]        id_ctrl,
  input  logic [2:0]        id_funct3,
  input  logic              id_funct7_5,
  input  logic              id_add_op,
  input  logic              flush,
  input  logic              wb_valid,
  input  logic [REG_AW-1:0] wb_rd_idx,
  input  logic [XLEN-1:0]   wb_data,
  input  logic [XLEN-1:0]   alu_result,
  input  logic              div_done,
  input  logic              div_by_zero,
  output logic [XLEN-1:0]   Rs1,
  output logic [XLEN-1:0]   Rs2,
  output logic [2:0]        IALU_ctrl,
  output logic [2:0]        Funct3,
  output logic              Funct7_5,
  output logic              Add_Op,
  output logic [REG_AW-1:0] ex_rd_idx,
  output logic              div_timeout
);
  import ex_issue_ctrl_pkg::*;

  localparam int CNT_W = $clog2(DIV_MAX_CYC + 1);

  issue_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load, hold, to_hit, div_wait, div_fin;
  logic [XLEN-1:0]  op1, op2;

`ifdef OPERAND_FWD_EN
  logic [1:0][REG_AW-1:0] src_idx;
  logic [1:0][XLEN-1:0]   src_rf, src_val;
  logic [1:0]             src_imm;

  assign src_idx = {id_rs2_idx, id_rs1_idx};
  assign src_rf  = {id_rs2_val, id_rs1_val};
  assign src_imm = {id_use_imm, 1'b0};

  // A div op only leaves DIV_WAIT with div_done/div_by_zero, so any op accepted
  // behind it sees a finished alu_result.
  for (genvar s = 0; s < 2; s++) begin : g_fwd
    operand_fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd (
      .idx        (src_idx[s]),
      .use_imm    (src_imm[s]),
      .rf_val     (src_rf[s]),
      .ex_rd_idx  (ex_rd_idx),
      .alu_result (alu_result),
      .wb_valid   (wb_valid),
      .wb_rd_idx  (wb_rd_idx),
      .wb_data    (wb_data),
      .val        (src_val[s])
    );
  end

  assign op1 = src_val[0];
  assign op2 = src_val[1];
`else
  logic unused_fwd;
  assign unused_fwd = ^{id_rs1_idx, id_rs2_idx, id_use_imm, wb_valid, wb_rd_idx,
                        wb_data, alu_result};
  assign op1 = id_rs1_val;
  assign op2 = id_rs2_val;
`endif

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Default outcome is bubble -> IDLE; flush wins over everything else.
  always_comb begin
    state_d  = ST_IDLE;
    cnt_d    = '0;
    load     = 1'b0;
    hold     = 1'b0;
    to_hit   = 1'b0;
    div_wait = (state_q == ST_DIV_WAIT);
    div_fin  = div_done | div_by_zero;
    id_ready = rst_n & (~div_wait | div_fin);
    if (flush) begin
      state_d = ST_IDLE;
    end else if (id_valid && id_ready) begin
      load    = 1'b1;
      state_d = (id_ctrl == ALU_DIV) ? ST_DIV_WAIT : ST_ISSUE;
    end else if (div_wait && !div_fin) begin
      if (cnt_q == CNT_W'(DIV_MAX_CYC - 1)) begin
        to_hit = 1'b1;
      end else begin
        hold    = 1'b1;
        state_d = ST_DIV_WAIT;
        cnt_d   = cnt_q + CNT_W'(1);
      end
    end
  end

  // Operand/funct fields are left as-is on a bubble; only ctrl and rd mark it.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      Rs1         <= '0;
      Rs2         <= '0;
      IALU_ctrl   <= ALU_BUBBLE;
      Funct3      <= '0;
      Funct7_5    <= 1'b0;
      Add_Op      <= 1'b0;
      ex_rd_idx   <= '0;
      div_timeout <= 1'b0;
    end else begin
      if (to_hit) div_timeout <= 1'b1;
      if (load) begin
        Rs1       <= op1;
        Rs2       <= op2;
        IALU_ctrl <= id_ctrl;
        Funct3    <= id_funct3;
        Funct7_5  <= id_funct7_5;
        Add_Op    <= id_add_op;
        ex_rd_idx <= id_rd_idx;
      end else if (!hold) begin
        IALU_ctrl <= ALU_BUBBLE;
        ex_rd_idx <= '0;
      end
    end
  end

endmodule
